// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one memory request at a time,
// and hands each instruction with its PC to the core over a valid/ready handshake.
module ysyx_24100005_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ERR_INST = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        mem_resp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic        stale_r, stale_s;
  logic [31:0] inst_q_r, inst_q_s;
  logic [31:0] pc_q_r, pc_q_s;
  logic        fetch_err_r, fetch_err_s;
  logic [31:0] redir_pc_s;
  logic        redir_misalign_s;

  assign redir_pc_s       = {redirect_pc[31:2], 2'b00};
  assign redir_misalign_s = (redirect_pc[1:0] != 2'b00);

  // State and datapath registers; reset is asynchronous, active-low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      stale_r     <= 1'b0;
      inst_q_r    <= 32'h0000_0000;
      pc_q_r      <= 32'h0000_0000;
      fetch_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      stale_r     <= stale_s;
      inst_q_r    <= inst_q_s;
      pc_q_r      <= pc_q_s;
      fetch_err_r <= fetch_err_s;
    end
  end

  // Next-state logic; a redirect outranks every other event outside IDLE
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    stale_s     = stale_r;
    inst_q_s    = inst_q_r;
    pc_q_s      = pc_q_r;
    fetch_err_s = fetch_err_r;
    case (state_r)
      IDLE: begin
        state_s = REQ;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_s        = redir_pc_s;
          fetch_err_s = fetch_err_r | redir_misalign_s;
          // The old address was accepted this cycle; its response must be discarded
          if (mem_req_ready) begin
            stale_s = 1'b1;
            state_s = WAIT;
          end else begin
            state_s = REQ;
          end
        end else if (mem_req_ready) begin
          state_s = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_s        = redir_pc_s;
          fetch_err_s = fetch_err_r | redir_misalign_s;
          if (mem_resp_valid) begin
            stale_s = 1'b0;
            state_s = REQ;
          end else begin
            stale_s = 1'b1;
            state_s = WAIT;
          end
        end else if (mem_resp_valid) begin
          if (stale_r) begin
            stale_s = 1'b0;
            state_s = REQ;
          end else begin
            inst_q_s    = mem_resp_err ? ERR_INST : mem_resp_data;
            pc_q_s      = pc_r;
            fetch_err_s = fetch_err_r | mem_resp_err;
            state_s     = HOLD;
          end
        end else begin
          state_s = WAIT;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_s        = redir_pc_s;
          fetch_err_s = fetch_err_r | redir_misalign_s;
          state_s     = REQ;
        end else if (out_ready) begin
          pc_s    = pc_r + 32'd4;
          state_s = REQ;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign mem_req_valid = (state_r == REQ);
  assign mem_req_addr  = pc_r;
  assign out_valid     = (state_r == HOLD);
  assign out_inst      = inst_q_r;
  assign out_pc        = pc_q_r;
  assign fetch_err     = fetch_err_r;

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Self-checking bench for ysyx_24100005_ifu: directed scenarios followed by randomized
// traffic, checked against a transaction-level model of the expected fetch stream.
module tb_ysyx_24100005_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] ERR_INST = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  always #5 clk = ~clk;

  ysyx_24100005_ifu #(.RESET_PC(RESET_PC), .ERR_INST(ERR_INST)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_err(fetch_err)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          lat = 1;
  int          cnt = 0;
  int          delivered = 0;
  logic        pend = 1'b0;
  logic [31:0] resp_addr = 32'h0;
  logic [31:0] exp_pc;
  logic        exp_err;
  logic [31:0] held_inst;

  // Memory image: a fixed word at the reset vector, hashed contents elsewhere
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == RESET_PC) return 32'h0000_0413;
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  function automatic logic err_at(input logic [31:0] a);
    return (a[9:2] == 8'h03);
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    return err_at(a) ? ERR_INST : mem_data(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
    check({tag, "_req_addr"},  mem_req_addr, RESET_PC);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_inst"},  out_inst, 32'd0);
    check({tag, "_out_pc"},    out_pc, 32'd0);
    check({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
  endtask

  // One clock cycle, entered and left at a falling edge: drive, check, update model
  task automatic step(input logic rdy, input logic ordy, input logic rv, input logic [31:0] rpc);
    logic resp_now;
    resp_now = 1'b0;
    if (pend) begin
      if (cnt <= 1) begin
        resp_now = 1'b1;
        pend = 1'b0;
      end else begin
        cnt--;
      end
    end
    mem_req_ready  = rdy;
    out_ready      = ordy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    mem_resp_valid = resp_now;
    mem_resp_data  = resp_now ? mem_data(resp_addr) : $urandom;
    mem_resp_err   = resp_now ? err_at(resp_addr) : 1'($urandom);
    if (rst) begin
      if (out_valid) begin
        check("out_pc", out_pc, exp_pc);
        check("out_inst", out_inst, exp_inst(exp_pc));
        if (err_at(exp_pc)) exp_err = 1'b1;
      end
      if (mem_req_valid && !rv) check("req_addr", mem_req_addr, exp_pc);
      check("fetch_err", 32'(fetch_err), 32'(exp_err));
      if (mem_req_valid && rdy) begin
        pend = 1'b1;
        cnt = lat;
        resp_addr = mem_req_addr;
      end
      if (out_valid && ordy) delivered++;
      if (rv && cyc >= 1) begin
        exp_pc = {rpc[31:2], 2'b00};
        if (rpc[1:0] != 2'b00) exp_err = 1'b1;
      end else if (out_valid && ordy) begin
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Reset asserted between clock edges; a late response must not produce an instruction
  task automatic async_reset();
    #2 rst = 1'b0;
    #1 check_reset("async");
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1234_5678;
    mem_resp_err   = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    mem_req_ready  = 1'b1;
    @(posedge clk);
    #1 check("late_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    pend    = 1'b0;
    exp_pc  = RESET_PC;
    exp_err = 1'b0;
    rst     = 1'b1;
    cyc     = 0;
  endtask

  task automatic run_until_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      n++;
    end
    check({tag, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 3))
      0:       return RESET_PC + 32'($urandom_range(0, 63)) * 32'd4;
      1:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
      2:       return $urandom;
      default: return RESET_PC + 32'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    rst = 1'b0;
    mem_req_ready = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    mem_resp_valid = 1'b0; mem_resp_data = 32'h0; mem_resp_err = 1'b0;
    exp_pc = RESET_PC;
    exp_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset("por");

    // Reset release and first fetch, 1-cycle memory
    rst = 1'b1;
    cyc = 0;
    lat = 1;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("first_req_valid", 32'(mem_req_valid), 32'd1);
    check("first_req_addr", mem_req_addr, RESET_PC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("first_valid_cyc", 32'(out_valid), 32'd1);
    check("first_pc", out_pc, RESET_PC);
    check("first_inst", out_inst, 32'h0000_0413);

    // Backpressure: output held for 5 cycles
    held_inst = out_inst;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_inst", out_inst, held_inst);
      step(1'b0, 1'b0, 1'b0, 32'h0);
    end
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("seq_req_addr", mem_req_addr, 32'h8000_0004);

    // Redirect while waiting on the 0x8000_0008 response
    run_until_valid("seq2");
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("req8_addr", mem_req_addr, 32'h8000_0008);
    lat = 2;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h8000_0100);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("stale_dropped", 32'(out_valid), 32'd0);
    check("redir_req_addr", mem_req_addr, 32'h8000_0100);
    run_until_valid("redir_wait");
    check("redir_out_pc", out_pc, 32'h8000_0100);

    // Redirect together with out_ready in HOLD
    step(1'b1, 1'b1, 1'b1, 32'h8000_0040);
    check("hold_redir_addr", mem_req_addr, 32'h8000_0040);

    // Redirect to 0x8000_000C in REQ with ready high; that fetch faults
    step(1'b1, 1'b0, 1'b1, 32'h8000_000C);
    run_until_valid("err");
    check("err_pc", out_pc, 32'h8000_000C);
    check("err_inst", out_inst, ERR_INST);
    check("err_flag", 32'(fetch_err), 32'd1);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    lat = 3;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("err_sticky", 32'(fetch_err), 32'd1);
    async_reset();

    // Misaligned redirect, then reset mid-WAIT
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h8000_0022);
    check("misalign_addr", mem_req_addr, 32'h8000_0020);
    check("misalign_err", 32'(fetch_err), 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    async_reset();

    // Randomized traffic
    delivered = 0;
    for (int i = 0; i < 4000; i++) begin
      logic rv;
      if ($urandom_range(0, 999) == 0) async_reset();
      lat = $urandom_range(1, 3);
      rv = (cyc >= 1) && ($urandom_range(0, 99) < 8);
      step(1'($urandom_range(0, 99) < 75), 1'($urandom_range(0, 99) < 60), rv, rand_target());
    end
    check("progress", 32'(delivered > 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
